// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: op codes, access sizes and FSM states.
// Also holds the alignment rule so the request path and any reuse agree on it.
package mem_stage_pkg;

  localparam int XLEN    = 32;
  localparam int REGBITS = 5;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    SIZE_B    = 2'b00,
    SIZE_H    = 2'b01,
    SIZE_W    = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Reserved size behaves as a word access.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between the memory stage and the data memory.
interface mem_stage_if #(parameter int XLEN = 32);

  logic            dmemReq;
  logic            dmemWe;
  logic [XLEN-1:0] dmemAddr;
  logic [XLEN-1:0] dmemWdata;
  logic [3:0]      dmemBe;
  logic            dmemAck;
  logic [XLEN-1:0] dmemRdata;

  modport master (
    output dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    input  dmemAck, dmemRdata
  );

  modport slave (
    input  dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    output dmemAck, dmemRdata
  );

endinterface

// File: rtl/mem_stage_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load extract plus extension.
// Purely combinational so one copy serves both the request and the response side.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_value
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte   = load_data[{addr_lo, 3'b000} +: 8];
    sel_half   = load_data[{addr_lo[1], 4'b0000} +: 16];
    byte_en    = 4'b1111;
    lane_wdata = store_data;
    load_value = load_data;
    case (size)
      SIZE_B: begin
        byte_en    = 4'b0001 << addr_lo;
        lane_wdata = {4{store_data[7:0]}};
        load_value = is_unsigned ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      SIZE_H: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{store_data[15:0]}};
        load_value = is_unsigned ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: runs one req/ack transaction per load/store, stalls execute while waiting,
// drops misaligned accesses with a one-cycle flag, and registers the writeback result.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    aluToMem,
  input  logic [XLEN-1:0]    memDin,
  input  logic [1:0]         memOp,
  input  logic [1:0]         memSize,
  input  logic               memUnsigned,
  input  logic [REGBITS-1:0] rdIn,
  input  logic               regWriteIn,
  mem_stage_if.master        dmem,
  output logic               hold,
  output logic [XLEN-1:0]    wbData,
  output logic [REGBITS-1:0] wbRd,
  output logic               wbWe,
  output logic               misalign
);

  state_e             state;
  logic [1:0]         cap_addr_lo;
  mem_size_e          cap_size;
  logic               cap_unsigned;
  logic [REGBITS-1:0] cap_rd;
  logic               cap_reg_write;

  mem_op_e   op_in;
  mem_size_e size_in;
  logic      is_access;
  logic      is_store;
  logic      bad_align;

  logic [1:0]  lane_addr;
  mem_size_e   lane_size;
  logic        lane_unsigned;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] load_value;

  always_comb begin
    op_in     = mem_op_e'(memOp);
    size_in   = mem_size_e'(memSize);
    is_store  = (op_in == MEM_STORE);
    is_access = (op_in == MEM_LOAD) || is_store;
    bad_align = is_access && is_misaligned(size_in, aluToMem[1:0]);
  end

  // Live inputs steer the store lanes in IDLE; captured fields steer the load extract in ACCESS.
  always_comb begin
    lane_addr     = aluToMem[1:0];
    lane_size     = size_in;
    lane_unsigned = memUnsigned;
    if (state == ACCESS) begin
      lane_addr     = cap_addr_lo;
      lane_size     = cap_size;
      lane_unsigned = cap_unsigned;
    end
  end

  mem_lane_align u_lane_align (
    .addr_lo     (lane_addr),
    .size        (lane_size),
    .is_unsigned (lane_unsigned),
    .store_data  (memDin),
    .load_data   (dmem.dmemRdata),
    .byte_en     (lane_be),
    .lane_wdata  (lane_wdata),
    .load_value  (load_value)
  );

  always_comb begin
    hold = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:   hold = is_access && !bad_align;
        ACCESS: hold = !dmem.dmemAck;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      dmem.dmemReq   <= 1'b0;
      dmem.dmemWe    <= 1'b0;
      dmem.dmemAddr  <= '0;
      dmem.dmemWdata <= '0;
      dmem.dmemBe    <= 4'b0000;
      wbData         <= '0;
      wbRd           <= '0;
      wbWe           <= 1'b0;
      misalign       <= 1'b0;
      cap_addr_lo    <= 2'b00;
      cap_size       <= SIZE_B;
      cap_unsigned   <= 1'b0;
      cap_rd         <= '0;
      cap_reg_write  <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (!is_access) begin
            wbData <= aluToMem;
            wbRd   <= rdIn;
            wbWe   <= regWriteIn;
          end else if (bad_align) begin
            misalign <= 1'b1;
            wbWe     <= 1'b0;
          end else begin
            state          <= ACCESS;
            cap_addr_lo    <= aluToMem[1:0];
            cap_size       <= size_in;
            cap_unsigned   <= memUnsigned;
            cap_rd         <= rdIn;
            cap_reg_write  <= regWriteIn;
            dmem.dmemReq   <= 1'b1;
            dmem.dmemWe    <= is_store;
            dmem.dmemAddr  <= {aluToMem[XLEN-1:2], 2'b00};
            dmem.dmemBe    <= is_store ? lane_be : 4'b0000;
            dmem.dmemWdata <= lane_wdata;
            wbWe           <= 1'b0;
          end
        end
        ACCESS: begin
          if (dmem.dmemAck) begin
            state        <= IDLE;
            dmem.dmemReq <= 1'b0;
            dmem.dmemBe  <= 4'b0000;
            wbRd         <= cap_rd;
            if (dmem.dmemWe) begin
              wbWe <= 1'b0;
            end else begin
              wbData <= load_value;
              wbWe   <= cap_reg_write;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: an abstract per-instruction model sets expectations that one
// negedge compare process checks, plus literal checks that pin the model on the key vectors.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_to_mem, mem_din;
  logic [1:0]  mem_op, mem_size;
  logic        mem_unsigned;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        hold;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic        misalign;

  mem_stage_if #(.XLEN(32)) dmem_bus ();

  mem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .aluToMem    (alu_to_mem),
    .memDin      (mem_din),
    .memOp       (mem_op),
    .memSize     (mem_size),
    .memUnsigned (mem_unsigned),
    .rdIn        (rd_in),
    .regWriteIn  (reg_write_in),
    .dmem        (dmem_bus),
    .hold        (hold),
    .wbData      (wb_data),
    .wbRd        (wb_rd),
    .wbWe        (wb_we),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        check_en = 1'b0;
  logic        exp_hold = 1'b0, exp_req = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_wb_data = '0;
  logic [3:0]  exp_be = '0;
  logic [4:0]  exp_wb_rd = '0;
  logic        exp_wb_we = 1'b0, exp_misalign = 1'b0;

  int          hold_cnt = 0, mis_cnt = 0, req_cnt = 0;
  logic        record_hold = 1'b0;
  logic        hold_hist[$];
  logic [3:0]  seen_be;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [1:0] size, input logic [31:0] addr);
    return (int'(addr[1:0]) % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
    int n = nbytes(size);
    return 4'(((1 << n) - 1) << int'(addr[1:0]));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] din);
    logic [31:0] r;
    int n = nbytes(size);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = din[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic [31:0] addr,
                                             input logic uns, input logic [31:0] rdata);
    longint v;
    int n = nbytes(size);
    v = (longint'(rdata) >> (8 * int'(addr[1:0]))) & ((longint'(1) << (8 * n)) - 1);
    if (!uns && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("hold", {31'b0, hold}, {31'b0, exp_hold});
      checkOutput("dmemReq", {31'b0, dmem_bus.dmemReq}, {31'b0, exp_req});
      checkOutput("dmemBe", {28'b0, dmem_bus.dmemBe}, {28'b0, exp_be});
      if (exp_req) begin
        checkOutput("dmemWe", {31'b0, dmem_bus.dmemWe}, {31'b0, exp_we});
        checkOutput("dmemAddr", dmem_bus.dmemAddr, exp_addr);
        if (exp_we) checkOutput("dmemWdata", dmem_bus.dmemWdata, exp_wdata);
      end
      checkOutput("wbWe", {31'b0, wb_we}, {31'b0, exp_wb_we});
      if (exp_wb_we) begin
        checkOutput("wbData", wb_data, exp_wb_data);
        checkOutput("wbRd", {27'b0, wb_rd}, {27'b0, exp_wb_rd});
      end
      checkOutput("misalign", {31'b0, misalign}, {31'b0, exp_misalign});
      if (hold) hold_cnt++;
      if (misalign) mis_cnt++;
      if (dmem_bus.dmemReq) req_cnt++;
      if (record_hold) hold_hist.push_back(hold);
    end
  end

  // Entered and left at posedge+1; the bench plays the memory, acking after ack_delay wait cycles.
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] din,
                               input logic [4:0] rd, input logic rw, input int ack_delay,
                               input logic [31:0] rdata, input logic stray_ack);
    bit acc = (op == 2'b01) || (op == 2'b10);
    mem_op = op; mem_size = size; mem_unsigned = uns; alu_to_mem = addr; mem_din = din;
    rd_in = rd; reg_write_in = rw;
    dmem_bus.dmemAck = stray_ack; dmem_bus.dmemRdata = ~rdata;
    if (!acc) begin
      exp_hold = 1'b0;
      @(posedge clk); #1;
      exp_wb_data = addr; exp_wb_rd = rd; exp_wb_we = rw; exp_misalign = 1'b0;
    end else if (model_mis(size, addr)) begin
      exp_hold = 1'b0;
      @(posedge clk); #1;
      exp_misalign = 1'b1; exp_wb_we = 1'b0;
    end else begin
      exp_hold = 1'b1;
      @(posedge clk); #1;
      dmem_bus.dmemAck = 1'b0;
      seen_be = dmem_bus.dmemBe;
      exp_misalign = 1'b0; exp_wb_we = 1'b0; exp_req = 1'b1; exp_we = (op == 2'b10);
      exp_addr = {addr[31:2], 2'b00};
      exp_be = (op == 2'b10) ? model_be(size, addr) : 4'b0000;
      exp_wdata = model_wdata(size, din);
      for (int k = 0; k < ack_delay; k++) begin
        @(posedge clk); #1;
      end
      dmem_bus.dmemAck = 1'b1; dmem_bus.dmemRdata = rdata; exp_hold = 1'b0;
      @(posedge clk); #1;
      exp_req = 1'b0; exp_be = 4'b0000;
      if (op == 2'b01) begin
        exp_wb_we = rw; exp_wb_rd = rd; exp_wb_data = model_load(size, addr, uns, rdata);
      end else begin
        exp_wb_we = 1'b0;
      end
    end
    dmem_bus.dmemAck = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] pat;
    rst = 1'b1;
    alu_to_mem = '0; mem_din = '0; mem_op = 2'b00; mem_size = 2'b00; mem_unsigned = 1'b0;
    rd_in = '0; reg_write_in = 1'b0; dmem_bus.dmemAck = 1'b0; dmem_bus.dmemRdata = '0;
    #2;
    checkOutput("rst_dmemReq", {31'b0, dmem_bus.dmemReq}, 32'd0);
    checkOutput("rst_dmemBe", {28'b0, dmem_bus.dmemBe}, 32'd0);
    checkOutput("rst_dmemAddr", dmem_bus.dmemAddr, 32'd0);
    checkOutput("rst_dmemWdata", dmem_bus.dmemWdata, 32'd0);
    checkOutput("rst_wbWe", {31'b0, wb_we}, 32'd0);
    checkOutput("rst_wbData", wb_data, 32'd0);
    checkOutput("rst_misalign", {31'b0, misalign}, 32'd0);
    checkOutput("rst_hold", {31'b0, hold}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_en = 1'b1;

    $display("[TB] NONE passthrough with stray ack");
    hold_cnt = 0;
    applyStimulus(2'b00, 2'b10, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 32'h0, 1'b1);
    checkOutput("t1_wbData", wb_data, 32'h1234);
    checkOutput("t1_wbRd", {27'b0, wb_rd}, 32'd5);
    checkOutput("t1_wbWe", {31'b0, wb_we}, 32'd1);
    applyStimulus(2'b00, 2'b10, 1'b0, 32'h55, 32'h0, 5'd6, 1'b0, 0, 32'h0, 1'b0);
    checkOutput("t1_hold_cnt", hold_cnt, 32'd0);

    $display("[TB] STORE byte, ack after 3 wait cycles");
    hold_cnt = 0;
    applyStimulus(2'b10, 2'b00, 1'b0, 32'h103, 32'hAB, 5'd1, 1'b1, 3, 32'h0, 1'b0);
    checkOutput("t2_be", {28'b0, seen_be}, 32'h8);
    checkOutput("t2_addr", dmem_bus.dmemAddr, 32'h100);
    checkOutput("t2_wdata", dmem_bus.dmemWdata, 32'hABABABAB);
    checkOutput("t2_wbWe", {31'b0, wb_we}, 32'd0);
    checkOutput("t2_hold_cnt", hold_cnt, 32'd4);

    $display("[TB] LOAD half signed and unsigned");
    applyStimulus(2'b01, 2'b01, 1'b0, 32'h202, 32'h0, 5'd7, 1'b1, 0, 32'h80015A5A, 1'b0);
    checkOutput("t3_signed", wb_data, 32'hFFFF8001);
    applyStimulus(2'b01, 2'b01, 1'b1, 32'h202, 32'h0, 5'd7, 1'b1, 1, 32'h80015A5A, 1'b0);
    checkOutput("t3_unsigned", wb_data, 32'h00008001);

    $display("[TB] misaligned LOAD word");
    hold_cnt = 0; mis_cnt = 0; req_cnt = 0;
    applyStimulus(2'b01, 2'b10, 1'b0, 32'h301, 32'h0, 5'd3, 1'b1, 0, 32'h0, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 0, 32'h0, 1'b0);
    checkOutput("t4_mis_cnt", mis_cnt, 32'd1);
    checkOutput("t4_req_cnt", req_cnt, 32'd0);
    checkOutput("t4_hold_cnt", hold_cnt, 32'd0);

    $display("[TB] mixed lane vectors");
    applyStimulus(2'b10, 2'b01, 1'b0, 32'h22, 32'h1234CAFE, 5'd2, 1'b0, 0, 32'h0, 1'b0);
    checkOutput("lane_half_be", {28'b0, seen_be}, 32'hC);
    applyStimulus(2'b01, 2'b00, 1'b0, 32'h11, 32'h0, 5'd8, 1'b1, 2, 32'h00008000, 1'b0);
    checkOutput("lane_lb_signed", wb_data, 32'hFFFFFF80);
    applyStimulus(2'b01, 2'b00, 1'b1, 32'h13, 32'h0, 5'd9, 1'b1, 0, 32'hF0000000, 1'b0);
    applyStimulus(2'b01, 2'b11, 1'b0, 32'h40, 32'h0, 5'd10, 1'b1, 1, 32'hCAFEF00D, 1'b1);
    applyStimulus(2'b11, 2'b00, 1'b0, 32'h77, 32'h0, 5'd11, 1'b1, 0, 32'h0, 1'b0);
    applyStimulus(2'b10, 2'b01, 1'b0, 32'h21, 32'h1111, 5'd0, 1'b0, 0, 32'h0, 1'b0);
    applyStimulus(2'b10, 2'b10, 1'b0, 32'h48, 32'h01020304, 5'd0, 1'b0, 2, 32'h0, 1'b0);
    applyStimulus(2'b01, 2'b00, 1'b0, 32'h44, 32'h0, 5'd12, 1'b0, 0, 32'h000000FF, 1'b0);

    $display("[TB] back-to-back LOAD byte / STORE word");
    hold_cnt = 0; req_cnt = 0; hold_hist.delete(); record_hold = 1'b1;
    applyStimulus(2'b01, 2'b00, 1'b0, 32'h0, 32'h0, 5'd4, 1'b1, 0, 32'h123456F0, 1'b0);
    checkOutput("t5_load", wb_data, 32'hFFFFFFF0);
    applyStimulus(2'b10, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF, 5'd0, 1'b0, 0, 32'h0, 1'b0);
    record_hold = 1'b0;
    checkOutput("t5_req_cnt", req_cnt, 32'd2);
    checkOutput("t5_hold_len", hold_hist.size(), 32'd4);
    pat = 4'b1010;
    for (int i = 0; i < 4 && i < hold_hist.size(); i++)
      checkOutput("t5_hold_pat", {31'b0, hold_hist[i]}, {31'b0, pat[3-i]});

    $display("[TB] reset during ACCESS");
    mem_op = 2'b01; mem_size = 2'b10; mem_unsigned = 1'b0; alu_to_mem = 32'h400;
    rd_in = 5'd9; reg_write_in = 1'b1; exp_hold = 1'b1;
    @(posedge clk); #1;
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h400; exp_be = 4'b0000; exp_wb_we = 1'b0;
    @(negedge clk); #2;
    check_en = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("t6_req_async", {31'b0, dmem_bus.dmemReq}, 32'd0);
    checkOutput("t6_hold", {31'b0, hold}, 32'd0);
    checkOutput("t6_wbWe", {31'b0, wb_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_req = 1'b0; exp_be = 4'b0000; exp_wb_we = 1'b0; exp_misalign = 1'b0; exp_hold = 1'b0;
    check_en = 1'b1;
    applyStimulus(2'b00, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 0, 32'hFFFFFFFF, 1'b1);
    checkOutput("t6_late_ack_wbWe", {31'b0, wb_we}, 32'd0);
    checkOutput("t6_late_ack_req", {31'b0, dmem_bus.dmemReq}, 32'd0);
    applyStimulus(2'b00, 2'b10, 1'b0, 32'h9, 32'h0, 5'd1, 1'b1, 0, 32'h0, 1'b0);
    check_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
